multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the RV32I core datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the register write enables, the mux selects, the ALU operation and the memory request handshake. It sits beside the immediate decoder and the ALU, consuming the instruction register and the branch comparator result, and counts retired instructions.

## Interface
Parameters:
- RESET_STATE, FETCH (3'd0): state entered on reset.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_instr  in  32  instruction register content; valid from DECODE onward.
- i_br_taken  in  1  branch comparator result; sampled in EXEC.
- i_mem_ready  in  1  memory acknowledge for the current o_mem_req.
- o_state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- o_ir_we  out  1  load instruction register.
- o_pc_we  out  1  load PC.
- o_pc_sel  out  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = {alu[31:1],1'b0}.
- o_mem_req  out  1  memory request; held until i_mem_ready.
- o_mem_we  out  1  store strobe, valid with o_mem_req.
- o_addr_sel  out  1  memory address: 0 = PC, 1 = ALU result.
- o_alu_a_sel  out  2  ALU A operand: 0 = rs1, 1 = PC, 2 = zero.
- o_alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- o_alu_op  out  4  ALU operation code.
- o_rf_we  out  1  register file write enable.
- o_wb_sel  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = pc+4.
- o_illegal  out  1  sticky trap flag.
- o_retired  out  32  count of committed instructions.

## Operation
- Only the state register, the o_illegal flag and o_retired are registered. All other outputs are combinational in state and i_instr.
- Every output not explicitly asserted in a state is 0.
- Opcode class is taken from i_instr[6:0]:
  - LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011.
  - LUI 0110111, AUIPC 0010111, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - Any other opcode is illegal, including FENCE and SYSTEM.
- FETCH:
  - Asserts o_mem_req with o_addr_sel=0.
  - On i_mem_ready: o_ir_we=1 and go to DECODE. Otherwise stay.
- DECODE:
  - Single cycle with no enables.
  - Illegal opcode goes to TRAP; all legal opcodes go to EXEC.
- EXEC, by class:
  - OP: alu_a=0, alu_b=0, alu_op={i_instr[30], funct3}; go to WB.
  - OPIMM: alu_b=1. alu_op={i_instr[30], funct3} when funct3=101, otherwise {1'b0, funct3}. Go to WB.
  - LUI: alu_a=2, alu_b=1, ADD; go to WB.
  - AUIPC: alu_a=1, alu_b=1, ADD; go to WB.
  - LOAD/STORE: alu_a=0, alu_b=1, ADD; go to MEM.
  - BRANCH: o_pc_we=1, o_pc_sel = i_br_taken ? 1 : 0. Retire; go to FETCH.
  - JAL: o_rf_we=1, wb_sel=2, o_pc_we=1, pc_sel=1. Retire; go to FETCH.
  - JALR: alu_a=0, alu_b=1, ADD, o_rf_we=1, wb_sel=2, o_pc_we=1, pc_sel=2. Retire; go to FETCH.
- MEM:
  - Asserts o_mem_req, o_addr_sel=1, alu_a=0, alu_b=1, ADD (address held stable). o_mem_we=1 for STORE.
  - Waits for i_mem_ready.
  - On ack, LOAD goes to WB.
  - On ack, STORE asserts o_pc_we with pc_sel=0, retires and goes to FETCH.
- WB:
  - o_rf_we=1. wb_sel=1 for LOAD, otherwise 0, with ALU controls held as in EXEC.
  - o_pc_we=1, pc_sel=0. Retire; go to FETCH.
- TRAP:
  - Sets o_illegal=1 and stays until reset.
  - No enables asserted; o_retired frozen.
- Retire means o_retired increments by 1, modulo 2^32 (wraps 0xFFFFFFFF to 0). It increments exactly once per instruction, in the same cycle o_pc_we is asserted.

## Timing
- Reset (synchronous, any state): state=FETCH, o_illegal=0, o_retired=0.
  - Outputs in the first cycle after reset are FETCH outputs, so o_mem_req=1.
  - A pending memory request is abandoned; memory must tolerate a dropped request.
  - i_rst has priority over every transition and the retire increment.
- Cycles per instruction, with i_mem_ready=1 in the same cycle as the request:
  - BRANCH, JAL, JALR: 3.
  - OP, OPIMM, LUI, AUIPC: 4.
  - STORE: 4.
  - LOAD: 5.
- Each cycle of i_mem_ready=0 adds one cycle in FETCH or MEM.
- o_mem_req, o_mem_we and the address select stay stable while waiting.
- i_mem_ready while o_mem_req=0 is ignored.
- PC and register file writes in the same edge (JAL/JALR) use the old PC for pc+4.

## Structure
- Package multicycle_ctrl_pkg holds:
  - State encodings and opcode constants.
  - ALU op codes: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101.
  - pc_sel, alu_a_sel and wb_sel encodings.
- One sub-module is natural: instr_class_decode, a combinational decoder from opcode to one-hot class plus an illegal flag.
- FSM, counter and output decode live in multicycle_ctrl.

## Test plan
- ADD x3,x1,x2 (0x002081B3), i_mem_ready=1:
  - States go 0→1→2→4→0.
  - o_alu_op=0000 in EXEC.
  - o_rf_we and o_pc_we in WB.
  - o_retired goes 0→1.
- LW (0x0000A103) with i_mem_ready low for 3 cycles in MEM:
  - o_mem_req and o_addr_sel=1 are held for 4 cycles.
  - Then WB with wb_sel=1; total 8 cycles.
- BEQ:
  - With i_br_taken=1: pc_sel=1 in EXEC.
  - With i_br_taken=0: pc_sel=0.
  - Each takes 3 cycles and retires once.
- SRAI x1,x1,3 (0x4030D093): alu_op=1101 and alu_b_sel=1.
- Illegal opcode 0x0000000F:
  - DECODE goes to TRAP and o_illegal=1 persists for 10 cycles with no enables.
  - i_rst returns to FETCH with o_retired=0.
- Reset asserted mid-MEM of SW: next cycle state=0, o_mem_we=0, no retire.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// ALU operation codes, datapath mux selects and the decoded instruction class.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] FUNCT3_SHIFT_RIGHT = 3'b101;

  typedef struct packed {
    logic load;
    logic store;
    logic opimm;
    logic op;
    logic lui;
    logic auipc;
    logic branch;
    logic jal;
    logic jalr;
  } iclass_t;

  // Immediate shifts carry SRL/SRA in bit 30; every other OP-IMM has bit 30 as immediate data.
  function automatic logic [3:0] opimm_alu_op(input logic [2:0] funct3, input logic bit30);
    return (funct3 == FUNCT3_SHIFT_RIGHT) ? {bit30, funct3} : {1'b0, funct3};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_ctrl_if;

  logic [31:0] i_instr;
  logic        i_br_taken;
  logic        i_mem_ready;

  logic [2:0]  o_state;
  logic        o_ir_we;
  logic        o_pc_we;
  logic [1:0]  o_pc_sel;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_addr_sel;
  logic [1:0]  o_alu_a_sel;
  logic        o_alu_b_sel;
  logic [3:0]  o_alu_op;
  logic        o_rf_we;
  logic [1:0]  o_wb_sel;
  logic        o_illegal;
  logic [31:0] o_retired;

  modport master (
    input  i_instr, i_br_taken, i_mem_ready,
    output o_state, o_ir_we, o_pc_we, o_pc_sel, o_mem_req, o_mem_we, o_addr_sel,
           o_alu_a_sel, o_alu_b_sel, o_alu_op, o_rf_we, o_wb_sel, o_illegal, o_retired
  );

  modport slave (
    output i_instr, i_br_taken, i_mem_ready,
    input  o_state, o_ir_we, o_pc_we, o_pc_sel, o_mem_req, o_mem_we, o_addr_sel,
           o_alu_a_sel, o_alu_b_sel, o_alu_op, o_rf_we, o_wb_sel, o_illegal, o_retired
  );

endinterface

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// Combinational opcode classifier: one-hot instruction class plus illegal flag.
// FENCE, SYSTEM and every unlisted opcode are reported as illegal.
module instr_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_OPIMM:  cls.opimm  = 1'b1;
      OPC_OP:     cls.op     = 1'b1;
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      default:    illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle control FSM: 3-5 cycles per instruction plus one per memory wait cycle;
// memory requests are held stable until i_mem_ready, and TRAP is sticky until reset.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  multicycle_ctrl_if.master  bus
);

  state_t      state;
  state_t      state_nxt;
  logic        illegal_q;
  logic [31:0] retired_q;

  iclass_t     cls;
  logic        cls_illegal;
  logic [2:0]  funct3;

  logic [1:0]  alu_a_cls;
  logic        alu_b_cls;
  logic [3:0]  alu_op_cls;

  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;

  logic        unused_instr_bits;

  assign funct3            = bus.i_instr[14:12];
  assign unused_instr_bits = ^{bus.i_instr[31], bus.i_instr[29:15], bus.i_instr[11:7]};

  instr_class_decode u_class (
    .opcode  (bus.i_instr[6:0]),
    .cls     (cls),
    .illegal (cls_illegal)
  );

  // ALU setup depends only on the class, so EXEC, MEM and WB can all present the same operands.
  always_comb begin
    alu_a_cls  = ALU_A_RS1;
    alu_b_cls  = ALU_B_RS2;
    alu_op_cls = ALU_ADD;
    if (cls.op) begin
      alu_op_cls = {bus.i_instr[30], funct3};
    end else if (cls.opimm) begin
      alu_b_cls  = ALU_B_IMM;
      alu_op_cls = opimm_alu_op(funct3, bus.i_instr[30]);
    end else if (cls.lui) begin
      alu_a_cls = ALU_A_ZERO;
      alu_b_cls = ALU_B_IMM;
    end else if (cls.auipc) begin
      alu_a_cls = ALU_A_PC;
      alu_b_cls = ALU_B_IMM;
    end else if (cls.load || cls.store || cls.jalr) begin
      alu_b_cls = ALU_B_IMM;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = ADDR_PC;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = ALU_B_RS2;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;

    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PC;
        if (bus.i_mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        state_nxt = cls_illegal ? TRAP : EXEC;
      end

      EXEC: begin
        if (cls.branch) begin
          pc_we     = 1'b1;
          pc_sel    = bus.i_br_taken ? PC_IMM : PC_PLUS4;
          state_nxt = FETCH;
        end else if (cls.jal) begin
          rf_we     = 1'b1;
          wb_sel    = WB_PC4;
          pc_we     = 1'b1;
          pc_sel    = PC_IMM;
          state_nxt = FETCH;
        end else if (cls.jalr) begin
          alu_a_sel = alu_a_cls;
          alu_b_sel = alu_b_cls;
          alu_op    = alu_op_cls;
          rf_we     = 1'b1;
          wb_sel    = WB_PC4;
          pc_we     = 1'b1;
          pc_sel    = PC_ALU;
          state_nxt = FETCH;
        end else if (cls.load || cls.store) begin
          alu_a_sel = alu_a_cls;
          alu_b_sel = alu_b_cls;
          alu_op    = alu_op_cls;
          state_nxt = MEM;
        end else if (cls_illegal) begin
          state_nxt = TRAP;
        end else begin
          alu_a_sel = alu_a_cls;
          alu_b_sel = alu_b_cls;
          alu_op    = alu_op_cls;
          state_nxt = WB;
        end
      end

      MEM: begin
        mem_req   = 1'b1;
        addr_sel  = ADDR_ALU;
        mem_we    = cls.store;
        alu_a_sel = alu_a_cls;
        alu_b_sel = alu_b_cls;
        alu_op    = alu_op_cls;
        if (bus.i_mem_ready) begin
          if (cls.store) begin
            pc_we     = 1'b1;
            pc_sel    = PC_PLUS4;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end

      WB: begin
        rf_we     = 1'b1;
        wb_sel    = cls.load ? WB_MEM : WB_ALU;
        alu_a_sel = alu_a_cls;
        alu_b_sel = alu_b_cls;
        alu_op    = alu_op_cls;
        pc_we     = 1'b1;
        pc_sel    = PC_PLUS4;
        state_nxt = FETCH;
      end

      TRAP: begin
        state_nxt = TRAP;
      end

      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  // pc_we marks the single commit cycle of every instruction, so it also drives the retire count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RESET_STATE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == TRAP) begin
        illegal_q <= 1'b1;
      end
      if (pc_we) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign bus.o_state     = state;
  assign bus.o_ir_we     = ir_we;
  assign bus.o_pc_we     = pc_we;
  assign bus.o_pc_sel    = pc_sel;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_addr_sel  = addr_sel;
  assign bus.o_alu_a_sel = alu_a_sel;
  assign bus.o_alu_b_sel = alu_b_sel;
  assign bus.o_alu_op    = alu_op;
  assign bus.o_rf_we     = rf_we;
  assign bus.o_wb_sel    = wb_sel;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle control
// vectors by a phase-level model; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic [1:0]  alu_a;
    logic        alu_b;
    logic [3:0]  alu_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [31:0] retired;
  } vec_t;

  typedef enum int {C_LOAD, C_STORE, C_OPIMM, C_OP, C_LUI, C_AUIPC, C_BR, C_JAL, C_JALR, C_ILL} cls_e;

  bit          clk = 1'b0;
  logic        i_rst;
  multicycle_ctrl_if bus();

  vec_t        exp_q[$];
  vec_t        mon_e;
  vec_t        mon_a;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] m_retired = '0;
  bit          m_illegal = 1'b0;

  multicycle_ctrl dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic cls_e classify(input logic [6:0] opc);
    case (opc)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_OPIMM;
      7'b0110011: return C_OP;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic vec_t blank(input logic [2:0] st);
    vec_t v;
    v         = '0;
    v.state   = st;
    v.retired = m_retired;
    v.illegal = m_illegal;
    return v;
  endfunction

  // ALU operand/op choice straight from the instruction-class rules.
  function automatic vec_t with_alu(input vec_t vin, input cls_e c, input logic [31:0] ins);
    vec_t v;
    logic [2:0] f3;
    v  = vin;
    f3 = ins[14:12];
    case (c)
      C_OP:    begin v.alu_a = 2'd0; v.alu_b = 1'b0; v.alu_op = {ins[30], f3}; end
      C_OPIMM: begin v.alu_b = 1'b1; v.alu_op = (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3}; end
      C_LUI:   begin v.alu_a = 2'd2; v.alu_b = 1'b1; v.alu_op = 4'd0; end
      C_AUIPC: begin v.alu_a = 2'd1; v.alu_b = 1'b1; v.alu_op = 4'd0; end
      default: begin v.alu_a = 2'd0; v.alu_b = 1'b1; v.alu_op = 4'd0; end
    endcase
    return v;
  endfunction

  task automatic step(input vec_t e, input bit rdy, input bit rst);
    bus.i_mem_ready = rdy;
    i_rst           = rst;
    exp_q.push_back(e);
    if (e.pc_we) m_retired = m_retired + 32'd1;
    if (rst) begin
      m_retired = '0;
      m_illegal = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // fw/mw: ready-low cycles in fetch/memory; mem_rst >= 0 resets on that memory wait cycle.
  task automatic do_instr(input logic [31:0] ins, input bit br, input int fw, input int mw,
                          input int mem_rst);
    vec_t v;
    cls_e c;
    bus.i_instr    = ins;
    bus.i_br_taken = br;
    c = classify(ins[6:0]);
    for (int i = 0; i <= fw; i++) begin
      v = blank(3'd0);
      v.mem_req = 1'b1;
      v.ir_we   = (i == fw);
      step(v, i == fw, 1'b0);
    end
    step(blank(3'd1), rbit(), 1'b0);
    if (c == C_ILL) return;

    v = blank(3'd2);
    case (c)
      C_BR:    begin v.pc_we = 1'b1; v.pc_sel = br ? 2'd1 : 2'd0; end
      C_JAL:   begin v.rf_we = 1'b1; v.wb_sel = 2'd2; v.pc_we = 1'b1; v.pc_sel = 2'd1; end
      C_JALR:  begin
        v = with_alu(v, c, ins);
        v.rf_we = 1'b1; v.wb_sel = 2'd2; v.pc_we = 1'b1; v.pc_sel = 2'd2;
      end
      default: v = with_alu(v, c, ins);
    endcase
    step(v, rbit(), 1'b0);
    if (c == C_BR || c == C_JAL || c == C_JALR) return;

    if (c == C_LOAD || c == C_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        v = with_alu(blank(3'd3), c, ins);
        v.mem_req  = 1'b1;
        v.addr_sel = 1'b1;
        v.mem_we   = (c == C_STORE);
        if (i == mem_rst) begin
          step(v, 1'b0, 1'b1);
          return;
        end
        if (i == mw && c == C_STORE) v.pc_we = 1'b1;
        step(v, i == mw, 1'b0);
      end
      if (c == C_STORE) return;
    end

    v = with_alu(blank(3'd4), c, ins);
    v.rf_we  = 1'b1;
    v.wb_sel = (c == C_LOAD) ? 2'd1 : 2'd0;
    v.pc_we  = 1'b1;
    step(v, rbit(), 1'b0);
  endtask

  task automatic do_trap(input logic [31:0] ins, input int fw, input int hold);
    do_instr(ins, rbit(), fw, 0, -1);
    m_illegal = 1'b1;
    repeat (hold) step(blank(3'd5), rbit(), 1'b0);
    step(blank(3'd5), 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.o_state, bus.o_ir_we, bus.o_pc_we, bus.o_pc_sel, bus.o_mem_req,
               bus.o_mem_we, bus.o_addr_sel, bus.o_alu_a_sel, bus.o_alu_b_sel,
               bus.o_alu_op, bus.o_rf_we, bus.o_wb_sel, bus.o_illegal, bus.o_retired};
      checks++;
      if (mon_a === mon_e) passes++;
      else $display("FAIL cyc_vec t=%0t state=%0d: actual=%h required=%h (retired %0d vs %0d)",
                    $time, mon_e.state, mon_a, mon_e, mon_a.retired, mon_e.retired);
    end
  end

  initial begin
    logic [6:0]  opc_tab [9];
    logic [31:0] rnd;
    logic [6:0]  opc;
    int          r;

    opc_tab = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
                7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
    i_rst           = 1'b1;
    bus.i_instr     = '0;
    bus.i_br_taken  = 1'b0;
    bus.i_mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_instr(32'h002081B3, 1'b0, 0, 0, -1);  // ADD x3,x1,x2
    do_instr(32'h0000A103, 1'b0, 0, 3, -1);  // LW with 3 wait cycles in MEM
    do_instr(32'h00208063, 1'b1, 0, 0, -1);  // BEQ taken
    do_instr(32'h00208063, 1'b0, 0, 0, -1);  // BEQ not taken
    do_instr(32'h4030D093, 1'b0, 0, 0, -1);  // SRAI x1,x1,3
    do_instr(32'h0020A023, 1'b0, 1, 1, -1);  // SW
    do_instr(32'h008000EF, 1'b0, 0, 0, -1);  // JAL
    do_instr(32'h000080E7, 1'b0, 2, 0, -1);  // JALR
    do_instr(32'h123450B7, 1'b0, 0, 0, -1);  // LUI
    do_instr(32'h00001097, 1'b0, 0, 0, -1);  // AUIPC
    do_instr(32'h40208033, 1'b0, 0, 0, -1);  // SUB
    do_trap(32'h0000000F, 0, 10);            // FENCE traps, then reset
    do_instr(32'h0020A023, 1'b0, 0, 5, 2);   // SW reset mid-MEM
    do_instr(32'h002081B3, 1'b0, 0, 0, -1);

    for (int n = 0; n < 250; n++) begin
      rnd = $urandom();
      r   = $urandom_range(0, 19);
      if (r == 0) begin
        opc = 7'($urandom());
        while (classify(opc) != C_ILL) opc = 7'($urandom());
        do_trap({rnd[31:7], opc}, $urandom_range(0, 2), $urandom_range(1, 4));
      end else begin
        opc = opc_tab[$urandom_range(0, 8)];
        do_instr({rnd[31:7], opc}, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
      end
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: actual=%0d pending entries, required=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
